fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It owns the PC, drives instruction-cache requests and latches fetched words into the IF/ID register consumed by decode. It applies the hazard unit's `hazard` (stall) and `branch` (flush/redirect) outputs, and stops fetching after a HALT. A branch redirect that arrives during an outstanding I-cache miss is buffered until the miss completes.

---
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS core.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        hazard,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_WAIT = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] redir_pc_reg, redir_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] npc_reg, npc_next;
    logic        valid_reg, valid_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= RUN;
            pc_reg       <= PC_INIT;
            redir_pc_reg <= 32'd0;
            instr_reg    <= 32'd0;
            npc_reg      <= 32'd0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            redir_pc_reg <= redir_pc_next;
            instr_reg    <= instr_next;
            npc_reg      <= npc_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        redir_pc_next = redir_pc_reg;
        instr_next    = instr_reg;
        npc_next      = npc_reg;
        valid_next    = valid_reg;

        case (state_reg)
            RUN: begin
                if (branch) begin
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                    // Under a miss the cache keeps the old address; the target waits in redir_pc.
                    if (ihit) begin
                        pc_next = branch_target;
                    end else begin
                        redir_pc_next = branch_target;
                        state_next    = REDIR_WAIT;
                    end
                end else if (hazard) begin
                    pc_next = pc_reg;
                end else if (ihit) begin
                    instr_next = imemload;
                    npc_next   = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                    if (imemload[31:26] == HALT_OP) begin
                        state_next = HALTED;
                    end
                end else begin
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                end
            end

            REDIR_WAIT: begin
                if (branch) begin
                    redir_pc_next = branch_target;
                end
                // The word returned for the stale address is dropped.
                if (ihit) begin
                    pc_next    = branch ? branch_target : redir_pc_reg;
                    state_next = RUN;
                end
                if (!hazard) begin
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                end
            end

            HALTED: begin
                if (branch) begin
                    pc_next    = branch_target;
                    state_next = RUN;
                end
                if (!hazard) begin
                    instr_next = 32'd0;
                    npc_next   = 32'd0;
                    valid_next = 1'b0;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign imemaddr    = pc_reg;
    assign imemREN     = (state_reg != HALTED);
    assign if_id_instr = instr_reg;
    assign if_id_npc   = npc_reg;
    assign if_id_valid = valid_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;
    logic        fetch_inc;
    logic        stall_inc;

    assign fetch_inc = (state_reg == RUN) && !branch && !hazard && ihit;
    assign stall_inc = hazard || ((state_reg != HALTED) && !ihit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count_reg <= 32'd0;
            stall_count_reg <= 32'd0;
        end else begin
            if (fetch_inc) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (stall_inc) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, stalls, branches, redirect under miss, halt, wrap, reset.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        hazard;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int n_assert;
    int n_fail;
    int n_step;

    fetch_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .imemload     (imemload),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .hazard       (hazard),
        .branch       (branch),
        .branch_target(branch_target),
        .if_id_instr  (if_id_instr),
        .if_id_npc    (if_id_npc),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge and are sampled there too.
    task automatic step();
        @(posedge CLK);
        #1;
        n_step++;
        $display("cycle %0d: addr=%h ren=%b instr=%h npc=%h valid=%b",
                 n_step, imemaddr, imemREN, if_id_instr, if_id_npc, if_id_valid);
    endtask

    task automatic check_latch(input string tag, input logic [31:0] instr,
                               input logic [31:0] npc, input logic valid);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_npc"},   if_id_npc,   npc);
        check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_step   = 0;
        nRST = 1'b0;
        ihit = 1'b0;
        imemload = 32'd0;
        hazard = 1'b0;
        branch = 1'b0;
        branch_target = 32'd0;

        // Reset state
        #2;
        check("rst_addr", imemaddr, 32'h0);
        check("rst_ren", {31'd0, imemREN}, 32'd1);
        check_latch("rst", 32'h0, 32'h0, 1'b0);
        check("rst_fcnt", fetch_count, 32'h0);
        check("rst_scnt", stall_count, 32'h0);
        #2 nRST = 1'b1;

        // Sequential hits
        ihit = 1'b1; imemload = 32'h1000_0001;
        step();
        check_latch("hit1", 32'h1000_0001, 32'h4, 1'b1);
        check("hit1_addr", imemaddr, 32'h4);
        imemload = 32'h1000_0002;
        step();
        check_latch("hit2", 32'h1000_0002, 32'h8, 1'b1);
        check("hit2_addr", imemaddr, 32'h8);

        // Two-cycle stall at pc=8
        hazard = 1'b1; imemload = 32'hDEAD_BEEF;
        step();
        check("stall1_addr", imemaddr, 32'h8);
        check_latch("stall1", 32'h1000_0002, 32'h8, 1'b1);
        step();
        check("stall2_addr", imemaddr, 32'h8);
        check_latch("stall2", 32'h1000_0002, 32'h8, 1'b1);
        hazard = 1'b0; imemload = 32'h1000_0003;
        step();
        check_latch("resume", 32'h1000_0003, 32'hC, 1'b1);
        check("resume_addr", imemaddr, 32'hC);

        // Branch with hit
        branch = 1'b1; branch_target = 32'h40; imemload = 32'h1000_0004;
        step();
        check("br_addr", imemaddr, 32'h40);
        check_latch("br", 32'h0, 32'h0, 1'b0);
        branch_target = 32'h10;
        step();
        check("br2_addr", imemaddr, 32'h10);

        // Branch during a miss, hit three cycles later
        branch_target = 32'h80; ihit = 1'b0;
        step();
        check("rw0_addr", imemaddr, 32'h10);
        check_latch("rw0", 32'h0, 32'h0, 1'b0);
        branch = 1'b0;
        step();
        check("rw1_addr", imemaddr, 32'h10);
        step();
        check("rw2_addr", imemaddr, 32'h10);
        ihit = 1'b1; imemload = 32'h1234_5678;
        step();
        check("rw_done_addr", imemaddr, 32'h80);
        check_latch("rw_done", 32'h0, 32'h0, 1'b0);

        // HALT
        imemload = 32'hFC00_0000;
        step();
        check_latch("halt", 32'hFC00_0000, 32'h84, 1'b1);
        check("halt_ren", {31'd0, imemREN}, 32'd0);
        check("halt_addr", imemaddr, 32'h84);
        imemload = 32'h1000_0009;
        step();
        check("halted_ren", {31'd0, imemREN}, 32'd0);
        check("halted_addr", imemaddr, 32'h84);
        check_latch("halted", 32'h0, 32'h0, 1'b0);
        branch = 1'b1; branch_target = 32'h20;
        step();
        check("unhalt_addr", imemaddr, 32'h20);
        check("unhalt_ren", {31'd0, imemREN}, 32'd1);

        // PC wrap and unaligned target pass-through
        branch_target = 32'hFFFF_FFFC;
        step();
        check("wrap_tgt", imemaddr, 32'hFFFF_FFFC);
        branch = 1'b0; imemload = 32'h0000_0011;
        step();
        check_latch("wrap", 32'h0000_0011, 32'h0, 1'b1);
        check("wrap_addr", imemaddr, 32'h0);
        branch = 1'b1; branch_target = 32'h13;
        step();
        check("low_bits", imemaddr, 32'h13);

        // Newest redirect wins while waiting
        branch_target = 32'h100; ihit = 1'b0;
        step();
        branch_target = 32'h200;
        step();
        check("newest_hold", imemaddr, 32'h13);
        branch = 1'b0; ihit = 1'b1;
        step();
        check("newest_addr", imemaddr, 32'h200);

        // Asynchronous reset during REDIR_WAIT
        branch = 1'b1; branch_target = 32'h300; ihit = 1'b0;
        step();
        branch = 1'b0;
        nRST = 1'b0;
        #1;
        check("arst_addr", imemaddr, 32'h0);
        check("arst_valid", {31'd0, if_id_valid}, 32'd0);
        #2 nRST = 1'b1;
        ihit = 1'b1; imemload = 32'h0000_0022;
        step();
        check("arst_after_addr", imemaddr, 32'h4);
        check_latch("arst_after", 32'h0000_0022, 32'h4, 1'b1);

        // Counters: 5 hits, 2 misses, 1 stall
        nRST = 1'b0;
        #2 nRST = 1'b1;
        check("perf_rst_fcnt", fetch_count, 32'h0);
        check("perf_rst_scnt", stall_count, 32'h0);
        for (int i = 0; i < 5; i++) begin
            ihit = 1'b1; imemload = 32'h3000_0000 + i;
            step();
        end
        ihit = 1'b0;
        step();
        step();
        ihit = 1'b1; hazard = 1'b1;
        step();
        hazard = 1'b0; ihit = 1'b0;
        check("perf_addr", imemaddr, 32'h14);
`ifdef FETCH_PERF_EN
        check("perf_fcnt", fetch_count, 32'd5);
        check("perf_scnt", stall_count, 32'd3);
`else
        check("perf_fcnt", fetch_count, 32'd0);
        check("perf_scnt", stall_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
